md_unit: RTL

- Multiply/divide responder that executes the MDOp/start commands issued by the instruction decoder, one per cycle.
- Sits in the EX stage beside the ALU. Owns the HI/LO architectural registers.
- Returns Busy so the hazard logic stalls MD/mf/mt instructions in ID.
- Returns MDOut, the mfhi/mflo read data, to the EX result mux.

---
 rtl/md_unit_pkg.sv | 34 +++
 rtl/md_unit.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/md_unit_pkg.sv
// Shared multiply/divide definitions: MD opcode encoding, FSM state type and result record.
package md_unit_pkg;

  localparam logic [3:0] MD_Free  = 4'd0;
  localparam logic [3:0] MD_Mult  = 4'd1;
  localparam logic [3:0] MD_Multu = 4'd2;
  localparam logic [3:0] MD_Div   = 4'd3;
  localparam logic [3:0] MD_Divu  = 4'd4;
  localparam logic [3:0] MD_Mfhi  = 4'd5;
  localparam logic [3:0] MD_Mflo  = 4'd6;
  localparam logic [3:0] MD_Mthi  = 4'd7;
  localparam logic [3:0] MD_Mtlo  = 4'd8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } md_result_t;

  // True for the opcodes that launch a multi-cycle operation.
  function automatic logic is_start_op(input logic [3:0] op);
    return (op == MD_Mult) || (op == MD_Multu) || (op == MD_Div) || (op == MD_Divu);
  endfunction

  // True for the multiply opcodes, which use the shorter busy period.
  function automatic logic is_mult_op(input logic [3:0] op);
    return (op == MD_Mult) || (op == MD_Multu);
  endfunction

endpackage

// File: rtl/md_unit.sv
// EX-stage multiply/divide unit owning HI/LO; computes the result at start, then holds
// Busy for a fixed number of cycles before committing it to HI/LO.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  MDOp,
  input  logic        flush,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDOut
);

  md_state_e   state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] hi_t_q, hi_t_d;
  logic [31:0] lo_t_q, lo_t_d;
  md_result_t  result;

  // Full result of a mult/multu/div/divu; divide by zero returns the current HI/LO so
  // the commit leaves them unchanged. Signed division works on magnitudes, which also
  // makes 0x80000000 / -1 wrap to 0x80000000 with a zero remainder.
  function automatic md_result_t calc_result(input logic [3:0]  op,
                                             input logic [31:0] a,
                                             input logic [31:0] b,
                                             input logic [31:0] cur_hi,
                                             input logic [31:0] cur_lo);
    md_result_t  res;
    logic [63:0] prod;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] divisor;
    res.hi  = cur_hi;
    res.lo  = cur_lo;
    prod    = 64'd0;
    a_neg   = (op == MD_Div) && a[31];
    b_neg   = (op == MD_Div) && b[31];
    a_mag   = a_neg ? (32'd0 - a) : a;
    b_mag   = b_neg ? (32'd0 - b) : b;
    divisor = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag   = a_mag / divisor;
    r_mag   = a_mag % divisor;
    case (op)
      MD_Mult: begin
        prod   = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        res.hi = prod[63:32];
        res.lo = prod[31:0];
      end
      MD_Multu: begin
        prod   = {32'd0, a} * {32'd0, b};
        res.hi = prod[63:32];
        res.lo = prod[31:0];
      end
      MD_Div, MD_Divu: begin
        if (b != 32'd0) begin
          res.lo = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
          res.hi = a_neg ? (32'd0 - r_mag) : r_mag;
        end
      end
      default: begin
        res.hi = cur_hi;
        res.lo = cur_lo;
      end
    endcase
    return res;
  endfunction

  // Result of the operation presented this cycle, latched only when a start is accepted.
  always_comb begin
    result = calc_result(MDOp, A, B, hi_q, lo_q);
  end

  // Next-state logic: accept start or register moves in IDLE, count down and commit in RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    hi_t_d  = hi_t_q;
    lo_t_d  = lo_t_q;
    case (state_q)
      ST_IDLE: begin
        if (!flush) begin
          if (start && is_start_op(MDOp)) begin
            hi_t_d  = result.hi;
            lo_t_d  = result.lo;
            cnt_d   = is_mult_op(MDOp) ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
            state_d = ST_RUN;
          end else if (!start && (MDOp == MD_Mthi)) begin
            hi_d = A;
          end else if (!start && (MDOp == MD_Mtlo)) begin
            lo_d = A;
          end
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          hi_d    = hi_t_q;
          lo_d    = lo_t_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      hi_t_q  <= 32'd0;
      lo_t_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      hi_t_q  <= hi_t_d;
      lo_t_q  <= lo_t_d;
    end
  end

  // Busy covers the start cycle combinationally so a back-to-back MD op stalls in ID.
  always_comb begin
    Busy  = start | (state_q == ST_RUN);
    HI    = hi_q;
    LO    = lo_q;
    MDOut = 32'd0;
    if (MDOp == MD_Mfhi) begin
      MDOut = hi_q;
    end else if (MDOp == MD_Mflo) begin
      MDOut = lo_q;
    end
  end

endmodule
